// File: rtl/layer_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_seq_pkg
// Purpose  : Shared state encodings and widths for the layer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package layer_seq_pkg;

  localparam int STATE_W = 3;

  // Encodings are visible on the state output, so they are fixed values.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3
  } state_e;

endpackage : layer_seq_pkg
`default_nettype wire

// File: rtl/layer_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : layer_seq_if
// Purpose  : Control/status bundle between the layer sequencer and its
//            datapath/controller.
// Revision : 1.0 - initial release
// ============================================================================
interface layer_seq_if #(
  parameter int IDX_W = 1
);
  import layer_seq_pkg::*;

  logic               start;
  logic               layer_done;
  logic               abort;
  logic [STATE_W-1:0] state;
  logic [IDX_W-1:0]   layer_idx;
  logic               layer_start;
  logic               mem_sel;
  logic               busy;
  logic               frame_done;
  logic               err;

  // Controller side: issues requests, observes sequencer status.
  modport master (
    output start, layer_done, abort,
    input  state, layer_idx, layer_start, mem_sel, busy, frame_done, err
  );

  // Sequencer side.
  modport slave (
    input  start, layer_done, abort,
    output state, layer_idx, layer_start, mem_sel, busy, frame_done, err
  );

endinterface : layer_seq_if
`default_nettype wire

// File: rtl/layer_seq_wdog.sv
`default_nettype none
// ============================================================================
// Module   : layer_seq_wdog
// Purpose  : Per-layer RUN-cycle watchdog. Counts enabled cycles since the
//            last clear and flags expiry on the TIMEOUT_CYC-th enabled cycle.
// Revision : 1.0 - initial release
// ============================================================================
module layer_seq_wdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority; the count saturates so a stuck enable cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q < CNT_W'(TIMEOUT_CYC))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The cycle holding count TIMEOUT_CYC-1 is the TIMEOUT_CYC-th enabled cycle.
  assign expired = en && (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

endmodule : layer_seq_wdog
`default_nettype wire

// File: rtl/layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : layer_seq
// Purpose  : Frame sequencer launching NUM_LAYERS layers back to back with a
//            ping-pong buffer select that flips once per accepted frame.
//            Optional layer timeout enabled by macro LAYER_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
import layer_seq_pkg::*;

module layer_seq #(
  parameter int NUM_LAYERS  = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic           clk,
  input  logic           srst,
  layer_seq_if.slave     bus
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

  // Elaboration-time sanity hook for the configuration parameters.
  if ((NUM_LAYERS < 1) || (NUM_LAYERS > 16) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mem_sel_q, mem_sel_d;
  logic             err_q;
  logic             wdog_expired;

`ifdef LAYER_SEQ_TIMEOUT_EN
  logic err_d;

  layer_seq_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .srst    (srst),
    .clr     (state_q == ST_LAUNCH),
    .en      (state_q == ST_RUN),
    .expired (wdog_expired)
  );

  // Error is cleared by a new frame and set only by an unpreempted timeout.
  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && bus.start) begin
      err_d = 1'b0;
    end else if ((state_q == ST_RUN) && wdog_expired && !bus.abort && !bus.layer_done) begin
      err_d = 1'b1;
    end
  end

  // Sticky error register.
  always_ff @(posedge clk) begin
    if (srst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign wdog_expired = 1'b0;
  assign err_q        = 1'b0;
`endif

  // Next-state logic: abort beats layer_done, which beats the timeout.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mem_sel_d = mem_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_LAUNCH;
          idx_d     = '0;
          mem_sel_d = ~mem_sel_q;
        end
      end
      ST_LAUNCH: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (bus.layer_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LAUNCH;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else if (wdog_expired) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, index and buffer-select registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mem_sel_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mem_sel_q <= mem_sel_d;
    end
  end

  // Every output comes straight from a register or a state decode.
  assign bus.state       = state_q;
  assign bus.layer_idx   = idx_q;
  assign bus.layer_start = (state_q == ST_LAUNCH);
  assign bus.frame_done  = (state_q == ST_DONE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.mem_sel     = mem_sel_q;
  assign bus.err         = err_q;

endmodule : layer_seq
`default_nettype wire

// File: tb/tb_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_seq
// Purpose  : Self-checking bench for layer_seq. Three instances (2, 4 and 1
//            layers) run against a frame-level reference model; a directed
//            vector table and hand sequences cover the corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_seq;

  localparam int NI = 3;
  localparam int TO = 8;
`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       d_srst [NI];
  logic       d_start[NI];
  logic       d_ld   [NI];
  logic       d_ab   [NI];
  logic [2:0] o_state[NI];
  logic [3:0] o_idx  [NI];
  logic       o_ls   [NI];
  logic       o_mem  [NI];
  logic       o_busy [NI];
  logic       o_fd   [NI];
  logic       o_err  [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int NL = (gi == 0) ? 2 : ((gi == 1) ? 4 : 1);
    localparam int IW = (NL > 1) ? $clog2(NL) : 1;
    layer_seq_if #(.IDX_W(IW)) bus ();
    assign bus.start      = d_start[gi];
    assign bus.layer_done = d_ld[gi];
    assign bus.abort      = d_ab[gi];
    layer_seq #(.NUM_LAYERS(NL), .TIMEOUT_CYC(TO)) u_dut (
      .clk  (clk),
      .srst (d_srst[gi]),
      .bus  (bus)
    );
    assign o_state[gi] = bus.state;
    assign o_idx[gi]   = 4'(bus.layer_idx);
    assign o_ls[gi]    = bus.layer_start;
    assign o_mem[gi]   = bus.mem_sel;
    assign o_busy[gi]  = bus.busy;
    assign o_fd[gi]    = bus.frame_done;
    assign o_err[gi]   = bus.err;
  end

  // Reference model: frame position 0 idle, 1 launching, 2 running, 3 finishing.
  int m_pos [NI];
  int m_idx [NI];
  int m_run [NI];
  bit m_mem [NI];
  bit m_err [NI];

  int n_vec = 0;
  int n_bad = 0;

  function automatic int layers_of(int i);
    return (i == 0) ? 2 : ((i == 1) ? 4 : 1);
  endfunction

  task automatic model_edge(int i);
    if (d_srst[i]) begin
      m_pos[i] = 0; m_idx[i] = 0; m_run[i] = 0; m_mem[i] = 1'b1; m_err[i] = 1'b0;
      return;
    end
    if (m_pos[i] == 0) begin
      if (d_start[i]) begin
        m_pos[i] = 1; m_idx[i] = 0; m_mem[i] = !m_mem[i]; m_err[i] = 1'b0;
      end
    end else if (d_ab[i]) begin
      m_pos[i] = 0; m_idx[i] = 0;
    end else if (m_pos[i] == 1) begin
      m_pos[i] = 2; m_run[i] = 0;
    end else if (m_pos[i] == 2) begin
      if (d_ld[i]) begin
        if (m_idx[i] == layers_of(i) - 1) m_pos[i] = 3;
        else begin m_idx[i] = m_idx[i] + 1; m_pos[i] = 1; end
      end else begin
        m_run[i] = m_run[i] + 1;
        if (TO_EN && m_run[i] >= TO) begin
          m_err[i] = 1'b1; m_pos[i] = 0; m_idx[i] = 0;
        end
      end
    end else begin
      m_pos[i] = 0; m_idx[i] = 0;
    end
  endtask

  // Packed view: {err, frame_done, mem_sel, busy, layer_start, idx[3:0], state[2:0]}
  function automatic logic [11:0] dut_vec(int i);
    return {o_err[i], o_fd[i], o_mem[i], o_busy[i], o_ls[i], o_idx[i], o_state[i]};
  endfunction

  function automatic logic [11:0] model_vec(int i);
    return {m_err[i], m_pos[i] == 3, m_mem[i], m_pos[i] != 0, m_pos[i] == 1,
            4'(m_idx[i]), 3'(m_pos[i])};
  endfunction

  function automatic logic [11:0] mk(bit err, bit fd, bit mem, bit ls, int idx, int st);
    return {err, fd, mem, st != 0, ls, 4'(idx), 3'(st)};
  endfunction

  task automatic check(string name, int i, logic [11:0] got, logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t: got {err,fd,mem,busy,ls,idx,st}=%b required %b",
               name, i, $time, got, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NI; i++) begin
      d_srst[i] = 1'b0; d_start[i] = 1'b0; d_ld[i] = 1'b0; d_ab[i] = 1'b0;
    end
  endtask

  // One clock: model follows the edge, every instance is compared at negedge.
  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_edge(i);
    @(negedge clk);
    for (int i = 0; i < NI; i++) check("model", i, dut_vec(i), model_vec(i));
    clear_inputs();
  endtask

  typedef struct {
    logic       start;
    logic       ld;
    logic       ab;
    logic [2:0] st;
    logic [3:0] idx;
    logic       ls;
    logic       fd;
    logic       mem;
  } vec_t;

  vec_t tab[13];

  initial begin
    // Two-layer frames on instance 0: outputs expected after each applied cycle.
    tab[0]  = '{1'b1, 1'b0, 1'b0, 3'd1, 4'd0, 1'b1, 1'b0, 1'b0};
    tab[1]  = '{1'b0, 1'b0, 1'b0, 3'd2, 4'd0, 1'b0, 1'b0, 1'b0};
    tab[2]  = '{1'b0, 1'b1, 1'b0, 3'd1, 4'd1, 1'b1, 1'b0, 1'b0};
    tab[3]  = '{1'b0, 1'b0, 1'b0, 3'd2, 4'd1, 1'b0, 1'b0, 1'b0};
    tab[4]  = '{1'b1, 1'b0, 1'b0, 3'd2, 4'd1, 1'b0, 1'b0, 1'b0};
    tab[5]  = '{1'b0, 1'b1, 1'b0, 3'd3, 4'd1, 1'b0, 1'b1, 1'b0};
    tab[6]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    tab[7]  = '{1'b1, 1'b0, 1'b0, 3'd1, 4'd0, 1'b1, 1'b0, 1'b1};
    tab[8]  = '{1'b0, 1'b1, 1'b0, 3'd2, 4'd0, 1'b0, 1'b0, 1'b1};
    tab[9]  = '{1'b0, 1'b1, 1'b0, 3'd1, 4'd1, 1'b1, 1'b0, 1'b1};
    tab[10] = '{1'b0, 1'b0, 1'b0, 3'd2, 4'd1, 1'b0, 1'b0, 1'b1};
    tab[11] = '{1'b0, 1'b1, 1'b0, 3'd3, 4'd1, 1'b0, 1'b1, 1'b1};
    tab[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1};

    clear_inputs();
    for (int i = 0; i < NI; i++) d_srst[i] = 1'b1;
    cycle();
    for (int i = 0; i < NI; i++) check("reset", i, dut_vec(i), mk(0, 0, 1, 0, 0, 0));

    for (int v = 0; v < 13; v++) begin
      d_start[0] = tab[v].start; d_ld[0] = tab[v].ld; d_ab[0] = tab[v].ab;
      cycle();
      check($sformatf("table[%0d]", v), 0, dut_vec(0),
            {1'b0, tab[v].fd, tab[v].mem, tab[v].st != 3'd0, tab[v].ls, tab[v].idx, tab[v].st});
    end

    // Four layers: abort together with layer_done while running layer 2.
    d_start[1] = 1'b1; cycle();
    cycle();
    d_ld[1] = 1'b1; cycle();
    cycle();
    d_ld[1] = 1'b1; cycle();
    cycle();
    check("run_l2", 1, dut_vec(1), mk(0, 0, 0, 0, 2, 2));
    d_ld[1] = 1'b1; d_ab[1] = 1'b1; cycle();
    check("abort_vs_done", 1, dut_vec(1), mk(0, 0, 0, 0, 0, 0));
    cycle();
    check("abort_no_fd", 1, dut_vec(1), mk(0, 0, 0, 0, 0, 0));

    // Single layer: layer_done during launch is ignored, the next one finishes.
    d_start[2] = 1'b1; cycle();
    check("nl1_launch", 2, dut_vec(2), mk(0, 0, 0, 1, 0, 1));
    d_ld[2] = 1'b1; cycle();
    check("nl1_ld_in_launch", 2, dut_vec(2), mk(0, 0, 0, 0, 0, 2));
    d_ld[2] = 1'b1; cycle();
    check("nl1_done", 2, dut_vec(2), mk(0, 1, 0, 0, 0, 3));
    cycle();
    check("nl1_idle", 2, dut_vec(2), mk(0, 0, 0, 0, 0, 0));

    // Reset mid-frame while running layer 1.
    d_start[0] = 1'b1; cycle();
    cycle();
    d_ld[0] = 1'b1; cycle();
    cycle();
    check("run_l1", 0, dut_vec(0), mk(0, 0, 0, 0, 1, 2));
    d_srst[0] = 1'b1; cycle();
    check("srst_mid", 0, dut_vec(0), mk(0, 0, 1, 0, 0, 0));
    cycle();
    check("srst_after", 0, dut_vec(0), mk(0, 0, 1, 0, 0, 0));

`ifdef LAYER_SEQ_TIMEOUT_EN
    // Eight RUN cycles without layer_done end the frame with err set.
    d_start[0] = 1'b1; cycle();
    repeat (9) cycle();
    check("timeout", 0, dut_vec(0), mk(1, 0, 0, 0, 0, 0));
    d_start[0] = 1'b1; cycle();
    check("err_clear", 0, dut_vec(0), mk(0, 0, 1, 1, 0, 1));
`endif

    // Randomised traffic on all three instances against the model.
    repeat (3000) begin
      for (int i = 0; i < NI; i++) begin
        d_srst[i]  = ($urandom_range(0, 99) < 2);
        d_start[i] = ($urandom_range(0, 99) < 30);
        d_ld[i]    = ($urandom_range(0, 99) < 30);
        d_ab[i]    = ($urandom_range(0, 99) < 5);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_layer_seq
`default_nettype wire

// File: doc/layer_seq.md
LAYER_SEQ -- requirements
Module: layer_seq

Interface
REQ-001 SHALL provide parameter NUM_LAYERS, default 2, number of layers sequenced per frame (range 1..16).
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 4096, maximum RUN cycles per layer (used only with LAYER_SEQ_TIMEOUT_EN).
REQ-003 SHALL derive localparam IDX_W = (NUM_LAYERS>1) ? clog2(NUM_LAYERS) : 1.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 srst  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  frame start request; sampled only in IDLE.
REQ-007 layer_done  input  1  one-cycle pulse from datapath: current layer complete.
REQ-008 abort  input  1  terminate the frame from any non-IDLE state.
REQ-009 state  output  3  current FSM state encoding.
REQ-010 layer_idx  output  IDX_W  index of the active layer.
REQ-011 layer_start  output  1  one-cycle pulse launching layer layer_idx.
REQ-012 mem_sel  output  1  ping-pong buffer select: 0 bank A, 1 bank B.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 frame_done  output  1  one-cycle pulse after the last layer completes.
REQ-015 err  output  1  sticky layer-timeout flag.

Function
REQ-016 States SHALL be IDLE=0, LAUNCH=1, RUN=2, DONE=3; all other encodings SHALL go to IDLE on the next cycle.
REQ-017 IDLE: start=1 -> LAUNCH, layer_idx<=0, mem_sel toggles, err<=0; start=0 -> remain in IDLE.
REQ-018 mem_sel SHALL toggle only on a start accepted in IDLE; start in any other state SHALL be ignored.
REQ-019 LAUNCH SHALL last exactly one cycle, with layer_start=1, then go to RUN; layer_done in LAUNCH SHALL be ignored.
REQ-020 RUN: layer_done=1 with layer_idx<NUM_LAYERS-1 -> layer_idx+1, next state LAUNCH.
REQ-021 RUN: layer_done=1 with layer_idx==NUM_LAYERS-1 -> DONE, layer_idx held.
REQ-022 DONE SHALL last one cycle with frame_done=1, then go to IDLE with layer_idx<=0.
REQ-023 abort=1 in LAUNCH, RUN or DONE -> IDLE next cycle, layer_idx<=0, mem_sel held, no frame_done.
REQ-024 abort SHALL take priority over layer_done, and over the timeout, in the same cycle.
REQ-025 NUM_LAYERS=1: the first layer_done in RUN SHALL go directly to DONE.
REQ-026 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.
REQ-027 The start-to-first-layer_start latency SHALL be 1 cycle; layer_done-to-next-layer_start latency SHALL be 1 cycle.

Reset
REQ-028 srst=1 SHALL force state=IDLE, layer_idx=0, layer_start=0, frame_done=0, busy=0, err=0, mem_sel=1, overriding all inputs.
REQ-029 srst asserted mid-frame SHALL abandon the frame with no frame_done pulse.

Configuration
REQ-030 Macro LAYER_SEQ_TIMEOUT_EN defined: a cycle counter SHALL clear on entering RUN and increment each RUN cycle.
REQ-031 With the macro, the counter reaching TIMEOUT_CYC without layer_done SHALL set err=1 and force IDLE with layer_idx<=0 and no frame_done.
REQ-032 With the macro, a layer_done and a timeout in the same cycle SHALL count as layer_done.
REQ-033 Macro undefined: no counter SHALL be built, err SHALL be tied 0, and TIMEOUT_CYC SHALL be unused.

Structure
REQ-034 Package layer_seq_pkg SHALL hold the state encodings (IDLE, LAUNCH, RUN, DONE) and the state width constant 3.
REQ-035 The timeout counter SHALL be a sub-module layer_seq_wdog (ports clk, srst, clr, en, expired; parameter TIMEOUT_CYC), instantiated only under LAYER_SEQ_TIMEOUT_EN.

Verification
REQ-036 NUM_LAYERS=2, reset, start pulse -> mem_sel 1->0, layer_start at cycle+1 with layer_idx=0; layer_done -> layer_start with layer_idx=1; layer_done -> frame_done one cycle later, then IDLE.
REQ-037 Two back-to-back frames -> mem_sel 0 then 1; start asserted while busy -> no toggle, no state change.
REQ-038 NUM_LAYERS=4, abort in RUN at layer_idx=2 issued together with layer_done -> IDLE, layer_idx=0, no frame_done, mem_sel held.
REQ-039 NUM_LAYERS=1 -> single layer_start, then frame_done after the first layer_done; layer_done during LAUNCH is ignored.
REQ-040 LAYER_SEQ_TIMEOUT_EN with TIMEOUT_CYC=8 and no layer_done -> err=1 after 8 RUN cycles, state IDLE; the next start clears err.
REQ-041 srst pulsed in RUN at layer_idx=1 -> all outputs at reset values on the next cycle, mem_sel=1.
